// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bus front-end: FSM encoding, default
// timing constants and a saturating adder for the glitch counter.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HUNG   = 2'd2
    } bus_state_e;

    localparam int I2C_SYNC_STAGES = 2;
    localparam int I2C_FILT_LEN    = 3;
    localparam int I2C_TIMEOUT_CYC = 1000;

    // Adds up to two events per cycle; clamps so 254 + 2 lands on 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// One pad line: synchroniser chain followed by a persistence filter that
// only accepts a new level after FILT_LEN consecutive disagreeing samples.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int FILT_LEN    = I2C_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic filt,
    output logic filt_next,
    output logic glitch
);

    localparam int CNT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_q, filt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], line_in};
        filt_d = filt_q;
        cnt_d  = '0;
        glitch = 1'b0;
        if (synced != filt_q) begin
            // The FILT_LEN-th disagreeing sample commits the new level.
            if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
                filt_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (cnt_q != '0) begin
            glitch = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt      = filt_q;
    assign filt_next = filt_d;

endmodule

// File: rtl/i2c_bus_conditioner.sv
// Conditions raw SDA/SCL for the slave core: filtered levels, edge and
// START/STOP strobes, bus ownership FSM with SCL-low timeout, glitch counter.
module i2c_bus_conditioner
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int FILT_LEN    = I2C_FILT_LEN,
    parameter int TIMEOUT_CYC = I2C_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_f,
    output logic       scl_f,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic       bus_timeout,
    output logic [7:0] glitch_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

    // Index 0 is SDA, index 1 is SCL.
    logic [1:0] line_raw, line_cur, line_nxt, line_glitch;

    assign line_raw = {scl_in, sda_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            i2c_line_filter #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_LEN    (FILT_LEN)
            ) u_filt (
                .clk       (clk),
                .rst       (rst),
                .line_in   (line_raw[gi]),
                .filt      (line_cur[gi]),
                .filt_next (line_nxt[gi]),
                .glitch    (line_glitch[gi])
            );
        end
    endgenerate

    logic sda_cur, sda_nxt, scl_cur, scl_nxt;
    assign sda_cur = line_cur[0];
    assign sda_nxt = line_nxt[0];
    assign scl_cur = line_cur[1];
    assign scl_nxt = line_nxt[1];

    logic             scl_rise_q, scl_rise_d;
    logic             scl_fall_q, scl_fall_d;
    logic             start_det_q, start_det_d;
    logic             stop_det_q, stop_det_d;
    logic             bus_timeout_q, bus_timeout_d;
    logic [7:0]       glitch_cnt_q, glitch_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    bus_state_e       state_q, state_d;

    // Strobes are computed from the filter's next value so they line up
    // with the cycle the new level first shows on sda_f/scl_f.
    always_comb begin
        scl_rise_d   = ~scl_cur & scl_nxt;
        scl_fall_d   = scl_cur & ~scl_nxt;
        start_det_d  = scl_cur & scl_nxt & sda_cur & ~sda_nxt;
        stop_det_d   = scl_cur & scl_nxt & ~sda_cur & sda_nxt;
        glitch_cnt_d = sat_add8(glitch_cnt_q,
                                {1'b0, line_glitch[0]} + {1'b0, line_glitch[1]});
        tmo_cnt_d    = '0;
        if (state_q == ACTIVE && !scl_cur) begin
            tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
        end
        bus_timeout_d = (state_q == ACTIVE) && (tmo_cnt_d == TMO_MAX);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_det_q) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (start_det_q)        state_d = ACTIVE;
                else if (stop_det_q)    state_d = IDLE;
                else if (bus_timeout_d) state_d = HUNG;
            end
            HUNG: begin
                if (start_det_q)            state_d = ACTIVE;
                else if (sda_cur && scl_cur) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_rise_q    <= 1'b0;
            scl_fall_q    <= 1'b0;
            start_det_q   <= 1'b0;
            stop_det_q    <= 1'b0;
            bus_timeout_q <= 1'b0;
            glitch_cnt_q  <= '0;
            tmo_cnt_q     <= '0;
            state_q       <= IDLE;
        end else begin
            scl_rise_q    <= scl_rise_d;
            scl_fall_q    <= scl_fall_d;
            start_det_q   <= start_det_d;
            stop_det_q    <= stop_det_d;
            bus_timeout_q <= bus_timeout_d;
            glitch_cnt_q  <= glitch_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            state_q       <= state_d;
        end
    end

    assign sda_f       = sda_cur;
    assign scl_f       = scl_cur;
    assign scl_rise    = scl_rise_q;
    assign scl_fall    = scl_fall_q;
    assign start_det   = start_det_q;
    assign stop_det    = stop_det_q;
    assign bus_timeout = bus_timeout_q;
    assign bus_busy    = (state_q == ACTIVE);
    assign glitch_cnt  = glitch_cnt_q;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Bench for i2c_bus_conditioner: directed bus scenarios with literal checks
// plus randomized line activity, all compared every cycle to a behavioural model.
module tb_i2c_bus_conditioner;
    import i2c_pkg::*;

    localparam int SYNC = I2C_SYNC_STAGES;
    localparam int FL   = I2C_FILT_LEN;
    localparam int TMO  = I2C_TIMEOUT_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sda_in = 1'b1;
    logic       scl_in = 1'b1;
    logic       sda_f, scl_f, scl_rise, scl_fall, start_det, stop_det;
    logic       bus_busy, bus_timeout;
    logic [7:0] glitch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    i2c_bus_conditioner #(
        .SYNC_STAGES (SYNC),
        .FILT_LEN    (FL),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sda_in      (sda_in),
        .scl_in      (scl_in),
        .sda_f       (sda_f),
        .scl_f       (scl_f),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .start_det   (start_det),
        .stop_det    (stop_det),
        .bus_busy    (bus_busy),
        .bus_timeout (bus_timeout),
        .glitch_cnt  (glitch_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pad samples wait in a queue SYNC deep; a line's filtered level flips once
    // FL samples in a row disagree with it. Bus state: 0 idle, 1 active, 2 hung.
    int m_q_sda[$];
    int m_q_scl[$];
    int m_sda_f, m_scl_f, m_run_sda, m_run_scl, m_glitch;
    int m_rise, m_fall, m_start, m_stop, m_timeout, m_state, m_low;
    int m_ps, m_pc, m_ns, m_nc, m_lvl_s, m_lvl_c, m_g_s, m_g_c;
    bit model_valid = 1'b0;

    task automatic filt_step(input int lvl, input int filt_in, input int run_in,
                             output int filt_out, output int run_out, output int gl);
        filt_out = filt_in;
        run_out  = 0;
        gl       = 0;
        if (lvl != filt_in) begin
            if (run_in + 1 == FL) filt_out = lvl;
            else                  run_out  = run_in + 1;
        end else if (run_in > 0) begin
            gl = 1;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_q_sda.delete();
            m_q_scl.delete();
            for (int i = 0; i < SYNC; i++) begin
                m_q_sda.push_back(1);
                m_q_scl.push_back(1);
            end
            m_sda_f = 1; m_scl_f = 1; m_run_sda = 0; m_run_scl = 0; m_glitch = 0;
            m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0; m_timeout = 0;
            m_state = 0; m_low = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            m_ps = m_sda_f;
            m_pc = m_scl_f;
            m_lvl_s = m_q_sda.pop_front();
            m_lvl_c = m_q_scl.pop_front();
            m_q_sda.push_back(int'(sda_in));
            m_q_scl.push_back(int'(scl_in));
            filt_step(m_lvl_s, m_ps, m_run_sda, m_ns, m_run_sda, m_g_s);
            filt_step(m_lvl_c, m_pc, m_run_scl, m_nc, m_run_scl, m_g_c);
            m_glitch = (m_glitch + m_g_s + m_g_c > 255) ? 255 : m_glitch + m_g_s + m_g_c;
            if (m_state == 1 && m_pc == 0) m_low = (m_low < TMO) ? m_low + 1 : TMO;
            else                           m_low = 0;
            m_timeout = (m_state == 1 && m_low == TMO) ? 1 : 0;
            // FSM reacts to the START/STOP strobes that were visible last cycle
            case (m_state)
                0: if (m_start) m_state = 1;
                1: begin
                    if (m_start)        m_state = 1;
                    else if (m_stop)    m_state = 0;
                    else if (m_timeout) m_state = 2;
                end
                default: begin
                    if (m_start)                   m_state = 1;
                    else if (m_ps == 1 && m_pc == 1) m_state = 0;
                end
            endcase
            m_rise  = (m_pc == 0 && m_nc == 1) ? 1 : 0;
            m_fall  = (m_pc == 1 && m_nc == 0) ? 1 : 0;
            m_start = (m_pc == 1 && m_nc == 1 && m_ps == 1 && m_ns == 0) ? 1 : 0;
            m_stop  = (m_pc == 1 && m_nc == 1 && m_ps == 0 && m_ns == 1) ? 1 : 0;
            m_sda_f = m_ns;
            m_scl_f = m_nc;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("m_sda_f",       32'(sda_f),       m_sda_f);
            check("m_scl_f",       32'(scl_f),       m_scl_f);
            check("m_scl_rise",    32'(scl_rise),    m_rise);
            check("m_scl_fall",    32'(scl_fall),    m_fall);
            check("m_start_det",   32'(start_det),   m_start);
            check("m_stop_det",    32'(stop_det),    m_stop);
            check("m_bus_busy",    32'(bus_busy),    (m_state == 1) ? 1 : 0);
            check("m_bus_timeout", 32'(bus_timeout), m_timeout);
            check("m_glitch_cnt",  32'(glitch_cnt),  m_glitch);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda_in = b;
        cyc(8);
        scl_in = 1'b1;
        cyc(10);
        scl_in = 1'b0;
        cyc(10);
    endtask

    task automatic pulse(input logic on_sda, input logic on_scl, input int w);
        if (on_sda) sda_in = 1'b0;
        if (on_scl) scl_in = 1'b0;
        cyc(w);
        sda_in = 1'b1;
        scl_in = 1'b1;
        cyc(6);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sda_f"}, 32'(sda_f), 1);
        check({tag, "_scl_f"}, 32'(scl_f), 1);
        check({tag, "_busy"}, 32'(bus_busy), 0);
        check({tag, "_glitch"}, 32'(glitch_cnt), 0);
        check({tag, "_strobes"}, 32'({scl_rise, scl_fall, start_det, stop_det, bus_timeout}), 0);
    endtask

    initial begin
        rst = 1'b1; sda_in = 1'b1; scl_in = 1'b1;
        cyc(3);
        rst = 1'b0;

        // Idle after reset release
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check_reset_outputs("idle");
        end

        // START, then first SCL fall 40 cycles later
        sda_in = 1'b0;
        cyc(4); check("start_e4", 32'(start_det), 0);
        cyc(1); check("start_e5", 32'(start_det), 1); check("busy_e5", 32'(bus_busy), 0);
        cyc(1); check("start_e6", 32'(start_det), 0); check("busy_e6", 32'(bus_busy), 1);
        cyc(34);
        scl_in = 1'b0;
        cyc(4); check("fall_e44", 32'(scl_fall), 0);
        cyc(1); check("fall_e45", 32'(scl_fall), 1);
        cyc(5);

        // Data bits, repeated START, more bits, STOP
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
        sda_in = 1'b1; cyc(8);
        scl_in = 1'b1; cyc(10);
        sda_in = 1'b0;
        cyc(5); check("rstart_det", 32'(start_det), 1); check("rstart_busy", 32'(bus_busy), 1);
        cyc(1); check("rstart_busy_after", 32'(bus_busy), 1);
        scl_in = 1'b0; cyc(10);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        sda_in = 1'b0; cyc(8);
        scl_in = 1'b1; cyc(10);
        sda_in = 1'b1;
        cyc(5); check("stop_det", 32'(stop_det), 1); check("stop_busy", 32'(bus_busy), 1);
        cyc(1); check("stop_after", 32'(stop_det), 0); check("stop_busy_after", 32'(bus_busy), 0);
        cyc(10);

        // Glitch rejection and counter saturation
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(5);
        pulse(1'b0, 1'b1, 2);
        check("glitch_one", 32'(glitch_cnt), 1); check("glitch_scl_f", 32'(scl_f), 1);
        for (int i = 0; i < 126; i++) pulse(1'b1, 1'b1, 2);
        check("glitch_253", 32'(glitch_cnt), 253);
        pulse(1'b0, 1'b1, 1);
        check("glitch_254", 32'(glitch_cnt), 254);
        pulse(1'b1, 1'b1, 2);
        check("glitch_254p2", 32'(glitch_cnt), 255);
        for (int i = 0; i < 20; i++) pulse(1'b0, 1'b1, 2);
        check("glitch_sat", 32'(glitch_cnt), 255);
        check("glitch_busy", 32'(bus_busy), 0);

        // Simultaneous SDA/SCL fall: SCL edge only
        sda_in = 1'b0; scl_in = 1'b0;
        cyc(4); check("sim_fall_e4", 32'(scl_fall), 0);
        cyc(1); check("sim_fall_e5", 32'(scl_fall), 1);
        check("sim_start", 32'(start_det), 0); check("sim_sda_f", 32'(sda_f), 0);
        cyc(1); check("sim_busy", 32'(bus_busy), 0);
        sda_in = 1'b1; scl_in = 1'b1; cyc(10);
        check("sim_busy_end", 32'(bus_busy), 0);

        // SCL stuck low after START -> timeout
        sda_in = 1'b0; cyc(10);
        scl_in = 1'b0;
        cyc(4 + TMO);
        check("tmo_before", 32'(bus_timeout), 0); check("tmo_busy_before", 32'(bus_busy), 1);
        cyc(1);
        check("tmo_pulse", 32'(bus_timeout), 1); check("tmo_busy", 32'(bus_busy), 0);
        cyc(1); check("tmo_after", 32'(bus_timeout), 0);
        sda_in = 1'b1; scl_in = 1'b1; cyc(10);
        check("tmo_release_busy", 32'(bus_busy), 0);
        check("tmo_release_lines", 32'({sda_f, scl_f}), 3);

        // Reset in the middle of a transfer
        sda_in = 1'b0; cyc(10);
        scl_in = 1'b0; cyc(10);
        check("mid_busy", 32'(bus_busy), 1);
        rst = 1'b1;
        cyc(1);
        check_reset_outputs("mid_rst");
        sda_in = 1'b1; scl_in = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(10);

        // Randomized line activity
        for (int i = 0; i < 600; i++) begin
            int r;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1; cyc(1); rst = 1'b0;
            end
            r = int'($urandom_range(0, 3));
            if (r == 0 || r == 2) sda_in = ~sda_in;
            if (r == 1 || r == 2) scl_in = ~scl_in;
            cyc(int'($urandom_range(1, 10)));
        end
        sda_in = 1'b1; scl_in = 1'b1;
        cyc(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
